// File: rtl/biriscv_enc_pkg.sv
// Op select enum, encoding format classes and RV32IM field constants shared by
// the instruction encoder and anything that builds requests for it.
package biriscv_enc_pkg;

  typedef enum logic [5:0] {
    OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND,
    OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU,
    OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI, OP_JALR,
    OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
    OP_SLLI, OP_SRLI, OP_SRAI,
    OP_SB, OP_SH, OP_SW,
    OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU,
    OP_LUI, OP_AUIPC, OP_JAL,
    OP_CSRRW, OP_CSRRS, OP_CSRRC, OP_CSRRWI, OP_CSRRSI, OP_CSRRCI,
    OP_ECALL, OP_EBREAK, OP_WFI, OP_FENCE
  } op_e;

  typedef enum logic [3:0] {
    FMT_BAD, FMT_R, FMT_I, FMT_SH, FMT_S, FMT_B, FMT_U, FMT_J, FMT_CSR, FMT_SYS
  } fmt_e;

  localparam logic [6:0] OPC_OP_IMM = 7'h13, OPC_OP     = 7'h33, OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_STORE  = 7'h23, OPC_BRANCH = 7'h63, OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_AUIPC  = 7'h17, OPC_JAL    = 7'h6F, OPC_JALR   = 7'h67;
  localparam logic [6:0] OPC_SYSTEM = 7'h73, OPC_MISC_MEM = 7'h0F;

  localparam logic [6:0] F7_BASE = 7'h00, F7_ALT = 7'h20, F7_MULDIV = 7'h01;

  localparam logic [2:0] F3_ADD = 3'd0, F3_SLL = 3'd1, F3_SLT = 3'd2, F3_SLTU = 3'd3;
  localparam logic [2:0] F3_XOR = 3'd4, F3_SR  = 3'd5, F3_OR  = 3'd6, F3_AND  = 3'd7;
  localparam logic [2:0] F3_BEQ = 3'd0, F3_BNE = 3'd1, F3_BLT = 3'd4, F3_BGE  = 3'd5;
  localparam logic [2:0] F3_BLTU = 3'd6, F3_BGEU = 3'd7;
  localparam logic [2:0] F3_LSB = 3'd0, F3_LSH = 3'd1, F3_LSW = 3'd2, F3_LBU = 3'd4, F3_LHU = 3'd5;
  localparam logic [2:0] F3_CSRRW = 3'd1, F3_CSRRS = 3'd2, F3_CSRRC = 3'd3;
  localparam logic [2:0] F3_CSRRWI = 3'd5, F3_CSRRSI = 3'd6, F3_CSRRCI = 3'd7;

  localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
  localparam logic [31:0] INST_WFI    = 32'h1050_0073;
  localparam logic [31:0] INST_FENCE  = 32'h0000_000F;

endpackage

// File: rtl/biriscv_enc_fifo.sv
// Generic synchronous FIFO with occupancy count, flush and sync active-low reset.
// Head data reads zero whenever the FIFO is empty.
module biriscv_enc_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 33
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     valid_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign do_push = push_i & (count_q < (AW+1)'(DEPTH));
  assign do_pop  = pop_i & valid_o;

  always_ff @(posedge clk_i) begin
    if (!rst_i || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end

  assign valid_o = |count_q;
  assign data_o  = valid_o ? mem_q[rd_ptr_q] : '0;
  assign count_o = count_q;

endmodule

// File: rtl/biriscv_inst_encoder.sv
// Field-level request -> RV32IM opcode word encoder feeding a small output FIFO.
// Unencodable requests are queued as all-zero words tagged with an error bit.
module biriscv_inst_encoder
  import biriscv_enc_pkg::*;
#(
  parameter int DEPTH         = 4,
  parameter int ENABLE_MULDIV = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        flush_i,
  input  logic        req_valid_i,
  output logic        req_accept_o,
  input  logic [5:0]  req_op_i,
  input  logic [4:0]  req_rd_i,
  input  logic [4:0]  req_rs1_i,
  input  logic [4:0]  req_rs2_i,
  input  logic [31:0] req_imm_i,
  output logic        opcode_valid_o,
  output logic [31:0] opcode_o,
  output logic        opcode_error_o,
  input  logic        opcode_accept_i,
  output logic [15:0] encoded_count_o,
  output logic [7:0]  error_count_o
);
  localparam int   CW     = $clog2(DEPTH) + 1;
  localparam fmt_e MD_FMT = (ENABLE_MULDIV != 0) ? FMT_R : FMT_BAD;

  fmt_e        fmt;
  logic [6:0]  opc, f7;
  logic [2:0]  f3;
  logic [31:0] sys_word, word;
  logic        enc_err;
  logic        fits_i, fits_b, fits_j;
  logic [4:0]  rd, rs1, rs2;
  logic [31:0] imm;
  logic [CW-1:0] fifo_count;
  logic [32:0] fifo_data;
  logic        push, pop;
  logic [15:0] encoded_count_q;
  logic [7:0]  error_count_q;

  assign rd  = req_rd_i;
  assign rs1 = req_rs1_i;
  assign rs2 = req_rs2_i;
  assign imm = req_imm_i;

  // Range checks: upper bits must be a pure sign extension of the encodable field.
  assign fits_i = (&imm[31:11]) | ~(|imm[31:11]);
  assign fits_b = ((&imm[31:12]) | ~(|imm[31:12])) & ~imm[0];
  assign fits_j = ((&imm[31:20]) | ~(|imm[31:20])) & ~imm[0];

  always_comb begin
    fmt = FMT_BAD; opc = OPC_OP_IMM; f3 = 3'd0; f7 = F7_BASE; sys_word = '0;
    case (req_op_i)
      OP_ADD:    begin fmt = FMT_R; f3 = F3_ADD; end
      OP_SUB:    begin fmt = FMT_R; f3 = F3_ADD; f7 = F7_ALT; end
      OP_SLL:    begin fmt = FMT_R; f3 = F3_SLL; end
      OP_SLT:    begin fmt = FMT_R; f3 = F3_SLT; end
      OP_SLTU:   begin fmt = FMT_R; f3 = F3_SLTU; end
      OP_XOR:    begin fmt = FMT_R; f3 = F3_XOR; end
      OP_SRL:    begin fmt = FMT_R; f3 = F3_SR; end
      OP_SRA:    begin fmt = FMT_R; f3 = F3_SR; f7 = F7_ALT; end
      OP_OR:     begin fmt = FMT_R; f3 = F3_OR; end
      OP_AND:    begin fmt = FMT_R; f3 = F3_AND; end
      OP_MUL:    begin fmt = MD_FMT; f3 = 3'd0; f7 = F7_MULDIV; end
      OP_MULH:   begin fmt = MD_FMT; f3 = 3'd1; f7 = F7_MULDIV; end
      OP_MULHSU: begin fmt = MD_FMT; f3 = 3'd2; f7 = F7_MULDIV; end
      OP_MULHU:  begin fmt = MD_FMT; f3 = 3'd3; f7 = F7_MULDIV; end
      OP_DIV:    begin fmt = MD_FMT; f3 = 3'd4; f7 = F7_MULDIV; end
      OP_DIVU:   begin fmt = MD_FMT; f3 = 3'd5; f7 = F7_MULDIV; end
      OP_REM:    begin fmt = MD_FMT; f3 = 3'd6; f7 = F7_MULDIV; end
      OP_REMU:   begin fmt = MD_FMT; f3 = 3'd7; f7 = F7_MULDIV; end
      OP_ADDI:   begin fmt = FMT_I; f3 = F3_ADD; end
      OP_SLTI:   begin fmt = FMT_I; f3 = F3_SLT; end
      OP_SLTIU:  begin fmt = FMT_I; f3 = F3_SLTU; end
      OP_XORI:   begin fmt = FMT_I; f3 = F3_XOR; end
      OP_ORI:    begin fmt = FMT_I; f3 = F3_OR; end
      OP_ANDI:   begin fmt = FMT_I; f3 = F3_AND; end
      OP_JALR:   begin fmt = FMT_I; f3 = 3'd0; opc = OPC_JALR; end
      OP_LB:     begin fmt = FMT_I; f3 = F3_LSB; opc = OPC_LOAD; end
      OP_LH:     begin fmt = FMT_I; f3 = F3_LSH; opc = OPC_LOAD; end
      OP_LW:     begin fmt = FMT_I; f3 = F3_LSW; opc = OPC_LOAD; end
      OP_LBU:    begin fmt = FMT_I; f3 = F3_LBU; opc = OPC_LOAD; end
      OP_LHU:    begin fmt = FMT_I; f3 = F3_LHU; opc = OPC_LOAD; end
      OP_SLLI:   begin fmt = FMT_SH; f3 = F3_SLL; end
      OP_SRLI:   begin fmt = FMT_SH; f3 = F3_SR; end
      OP_SRAI:   begin fmt = FMT_SH; f3 = F3_SR; f7 = F7_ALT; end
      OP_SB:     begin fmt = FMT_S; f3 = F3_LSB; end
      OP_SH:     begin fmt = FMT_S; f3 = F3_LSH; end
      OP_SW:     begin fmt = FMT_S; f3 = F3_LSW; end
      OP_BEQ:    begin fmt = FMT_B; f3 = F3_BEQ; end
      OP_BNE:    begin fmt = FMT_B; f3 = F3_BNE; end
      OP_BLT:    begin fmt = FMT_B; f3 = F3_BLT; end
      OP_BGE:    begin fmt = FMT_B; f3 = F3_BGE; end
      OP_BLTU:   begin fmt = FMT_B; f3 = F3_BLTU; end
      OP_BGEU:   begin fmt = FMT_B; f3 = F3_BGEU; end
      OP_LUI:    begin fmt = FMT_U; opc = OPC_LUI; end
      OP_AUIPC:  begin fmt = FMT_U; opc = OPC_AUIPC; end
      OP_JAL:    fmt = FMT_J;
      OP_CSRRW:  begin fmt = FMT_CSR; f3 = F3_CSRRW; end
      OP_CSRRS:  begin fmt = FMT_CSR; f3 = F3_CSRRS; end
      OP_CSRRC:  begin fmt = FMT_CSR; f3 = F3_CSRRC; end
      OP_CSRRWI: begin fmt = FMT_CSR; f3 = F3_CSRRWI; end
      OP_CSRRSI: begin fmt = FMT_CSR; f3 = F3_CSRRSI; end
      OP_CSRRCI: begin fmt = FMT_CSR; f3 = F3_CSRRCI; end
      OP_ECALL:  begin fmt = FMT_SYS; sys_word = INST_ECALL; end
      OP_EBREAK: begin fmt = FMT_SYS; sys_word = INST_EBREAK; end
      OP_WFI:    begin fmt = FMT_SYS; sys_word = INST_WFI; end
      OP_FENCE:  begin fmt = FMT_SYS; sys_word = INST_FENCE; end
      default:   fmt = FMT_BAD;
    endcase
  end

  always_comb begin
    enc_err = 1'b0;
    word    = '0;
    case (fmt)
      FMT_R:   word = {f7, rs2, rs1, f3, rd, OPC_OP};
      FMT_I:   begin enc_err = ~fits_i; word = {imm[11:0], rs1, f3, rd, opc}; end
      FMT_SH:  begin enc_err = |imm[31:5]; word = {f7, imm[4:0], rs1, f3, rd, OPC_OP_IMM}; end
      FMT_S:   begin enc_err = ~fits_i; word = {imm[11:5], rs2, rs1, f3, imm[4:0], OPC_STORE}; end
      FMT_B:   begin
        enc_err = ~fits_b;
        word = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], OPC_BRANCH};
      end
      FMT_U:   begin enc_err = |imm[11:0]; word = {imm[31:12], rd, opc}; end
      FMT_J:   begin
        enc_err = ~fits_j;
        word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OPC_JAL};
      end
      FMT_CSR: begin enc_err = |imm[31:12]; word = {imm[11:0], rs1, f3, rd, OPC_SYSTEM}; end
      FMT_SYS: word = sys_word;
      default: enc_err = 1'b1;
    endcase
    if (enc_err) word = '0;
  end

  // No full-FIFO bypass: a same-cycle pop does not free a slot for the push.
  assign req_accept_o = rst_i & ~flush_i & (fifo_count < CW'(DEPTH));
  assign push         = req_valid_i & req_accept_o;
  assign pop          = opcode_valid_o & opcode_accept_i;

  biriscv_enc_fifo #(.DEPTH(DEPTH), .WIDTH(33)) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (flush_i),
    .push_i  (push),
    .data_i  ({enc_err, word}),
    .pop_i   (pop),
    .data_o  (fifo_data),
    .valid_o (opcode_valid_o),
    .count_o (fifo_count)
  );

  assign opcode_o       = fifo_data[31:0];
  assign opcode_error_o = fifo_data[32];

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      encoded_count_q <= '0;
      error_count_q   <= '0;
    end else begin
      if (pop && !flush_i) encoded_count_q <= encoded_count_q + 16'd1;
      if (push && enc_err && error_count_q != 8'hFF) error_count_q <= error_count_q + 8'd1;
    end
  end

  assign encoded_count_o = encoded_count_q;
  assign error_count_o   = error_count_q;

endmodule

// File: tb/tb_biriscv_inst_encoder.sv
// Self-checking bench for biriscv_inst_encoder: directed scenarios plus a randomized
// run scored against an arithmetic ISA-level encoding model and a queue.
module tb_biriscv_inst_encoder;
  import biriscv_enc_pkg::*;

  localparam int DEPTH = 4;
  localparam int ENABLE_MULDIV = 1;

  logic        clk = 1'b0;
  logic        rst_i, flush_i, req_valid_i, opcode_accept_i;
  logic        req_accept_o, opcode_valid_o, opcode_error_o;
  logic [5:0]  req_op_i;
  logic [4:0]  req_rd_i, req_rs1_i, req_rs2_i;
  logic [31:0] req_imm_i, opcode_o;
  logic [15:0] encoded_count_o;
  logic [7:0]  error_count_o;

  int checks = 0;
  int fails  = 0;
  logic [15:0] exp_enc;
  logic [7:0]  exp_errc;
  logic [32:0] sb[$];
  int bnd [0:12] = '{2047, 2048, -2048, -2049, 4094, 4095, 4096, -4096, -4097,
                     1048574, 1048576, -1048576, 31};

  always #5 clk = ~clk;

  biriscv_inst_encoder #(.DEPTH(DEPTH), .ENABLE_MULDIV(ENABLE_MULDIV)) dut (
    .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i),
    .req_valid_i(req_valid_i), .req_accept_o(req_accept_o), .req_op_i(req_op_i),
    .req_rd_i(req_rd_i), .req_rs1_i(req_rs1_i), .req_rs2_i(req_rs2_i), .req_imm_i(req_imm_i),
    .opcode_valid_o(opcode_valid_o), .opcode_o(opcode_o), .opcode_error_o(opcode_error_o),
    .opcode_accept_i(opcode_accept_i), .encoded_count_o(encoded_count_o),
    .error_count_o(error_count_o)
  );

  // ISA-level reference: classify the op, range-check the value, place fields arithmetically.
  function automatic logic [32:0] ref_encode(input logic [5:0] op, input logic [4:0] rd,
      input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm);
    byte fmt; bit e, md;
    longint opc, f3, f7, s, u, v, x, lrd, lrs1, lrs2;
    s = longint'($signed(imm)); u = longint'(imm);
    lrd = longint'(rd); lrs1 = longint'(rs1); lrs2 = longint'(rs2);
    fmt = "?"; opc = 'h13; f3 = 0; f7 = 0; md = 0; e = 0; x = 0; v = 0;
    case (op)
      OP_ADD:  begin fmt = "R"; f3 = 0; end       OP_SUB:   begin fmt = "R"; f3 = 0; f7 = 'h20; end
      OP_SLL:  begin fmt = "R"; f3 = 1; end       OP_SLT:   begin fmt = "R"; f3 = 2; end
      OP_SLTU: begin fmt = "R"; f3 = 3; end       OP_XOR:   begin fmt = "R"; f3 = 4; end
      OP_SRL:  begin fmt = "R"; f3 = 5; end       OP_SRA:   begin fmt = "R"; f3 = 5; f7 = 'h20; end
      OP_OR:   begin fmt = "R"; f3 = 6; end       OP_AND:   begin fmt = "R"; f3 = 7; end
      OP_MUL:  begin fmt = "R"; f3 = 0; f7 = 1; md = 1; end
      OP_MULH: begin fmt = "R"; f3 = 1; f7 = 1; md = 1; end
      OP_MULHSU: begin fmt = "R"; f3 = 2; f7 = 1; md = 1; end
      OP_MULHU: begin fmt = "R"; f3 = 3; f7 = 1; md = 1; end
      OP_DIV:  begin fmt = "R"; f3 = 4; f7 = 1; md = 1; end
      OP_DIVU: begin fmt = "R"; f3 = 5; f7 = 1; md = 1; end
      OP_REM:  begin fmt = "R"; f3 = 6; f7 = 1; md = 1; end
      OP_REMU: begin fmt = "R"; f3 = 7; f7 = 1; md = 1; end
      OP_ADDI: begin fmt = "I"; f3 = 0; end       OP_SLTI:  begin fmt = "I"; f3 = 2; end
      OP_SLTIU: begin fmt = "I"; f3 = 3; end      OP_XORI:  begin fmt = "I"; f3 = 4; end
      OP_ORI:  begin fmt = "I"; f3 = 6; end       OP_ANDI:  begin fmt = "I"; f3 = 7; end
      OP_JALR: begin fmt = "I"; f3 = 0; opc = 'h67; end
      OP_LB:   begin fmt = "I"; f3 = 0; opc = 'h03; end
      OP_LH:   begin fmt = "I"; f3 = 1; opc = 'h03; end
      OP_LW:   begin fmt = "I"; f3 = 2; opc = 'h03; end
      OP_LBU:  begin fmt = "I"; f3 = 4; opc = 'h03; end
      OP_LHU:  begin fmt = "I"; f3 = 5; opc = 'h03; end
      OP_SLLI: begin fmt = "H"; f3 = 1; end       OP_SRLI:  begin fmt = "H"; f3 = 5; end
      OP_SRAI: begin fmt = "H"; f3 = 5; f7 = 'h20; end
      OP_SB:   begin fmt = "S"; f3 = 0; end       OP_SH:    begin fmt = "S"; f3 = 1; end
      OP_SW:   begin fmt = "S"; f3 = 2; end
      OP_BEQ:  begin fmt = "B"; f3 = 0; end       OP_BNE:   begin fmt = "B"; f3 = 1; end
      OP_BLT:  begin fmt = "B"; f3 = 4; end       OP_BGE:   begin fmt = "B"; f3 = 5; end
      OP_BLTU: begin fmt = "B"; f3 = 6; end       OP_BGEU:  begin fmt = "B"; f3 = 7; end
      OP_LUI:  begin fmt = "U"; opc = 'h37; end   OP_AUIPC: begin fmt = "U"; opc = 'h17; end
      OP_JAL:  fmt = "J";
      OP_CSRRW: begin fmt = "C"; f3 = 1; end      OP_CSRRS:  begin fmt = "C"; f3 = 2; end
      OP_CSRRC: begin fmt = "C"; f3 = 3; end      OP_CSRRWI: begin fmt = "C"; f3 = 5; end
      OP_CSRRSI: begin fmt = "C"; f3 = 6; end     OP_CSRRCI: begin fmt = "C"; f3 = 7; end
      OP_ECALL:  begin fmt = "Z"; x = 'h00000073; end
      OP_EBREAK: begin fmt = "Z"; x = 'h00100073; end
      OP_WFI:    begin fmt = "Z"; x = 'h10500073; end
      OP_FENCE:  begin fmt = "Z"; x = 'h0000000F; end
      default: fmt = "?";
    endcase
    case (fmt)
      "R": begin
        e = md && (ENABLE_MULDIV == 0);
        x = (f7 << 25) | (lrs2 << 20) | (lrs1 << 15) | (f3 << 12) | (lrd << 7) | 'h33;
      end
      "I": begin
        e = (s < -2048) || (s > 2047);
        x = ((s & 'hFFF) << 20) | (lrs1 << 15) | (f3 << 12) | (lrd << 7) | opc;
      end
      "H": begin
        e = u > 31;
        x = (f7 << 25) | ((u & 31) << 20) | (lrs1 << 15) | (f3 << 12) | (lrd << 7) | 'h13;
      end
      "S": begin
        e = (s < -2048) || (s > 2047);
        x = (((s >> 5) & 127) << 25) | (lrs2 << 20) | (lrs1 << 15) | (f3 << 12) | ((s & 31) << 7) | 'h23;
      end
      "B": begin
        v = s & 'h1FFF;
        e = (s < -4096) || (s > 4094) || (s % 2 != 0);
        x = (((v >> 12) & 1) << 31) | (((v >> 5) & 63) << 25) | (lrs2 << 20) | (lrs1 << 15) |
            (f3 << 12) | (((v >> 1) & 15) << 8) | (((v >> 11) & 1) << 7) | 'h63;
      end
      "J": begin
        v = s & 'h1FFFFF;
        e = (s < -1048576) || (s > 1048574) || (s % 2 != 0);
        x = (((v >> 20) & 1) << 31) | (((v >> 1) & 1023) << 21) | (((v >> 11) & 1) << 20) |
            (((v >> 12) & 255) << 12) | (lrd << 7) | 'h6F;
      end
      "U": begin e = (u % 4096) != 0; x = u | (lrd << 7) | opc; end
      "C": begin
        e = u > 'hFFF;
        x = (u << 20) | (lrs1 << 15) | (f3 << 12) | (lrd << 7) | 'h73;
      end
      "Z": e = 0;
      default: e = 1;
    endcase
    if (e) x = 0;
    return {e, x[31:0]};
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic drive_req(input logic [5:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                           input logic [4:0] rs2, input logic [31:0] imm);
    req_valid_i = 1'b1; req_op_i = op; req_rd_i = rd; req_rs1_i = rs1; req_rs2_i = rs2;
    req_imm_i = imm;
  endtask

  task automatic do_reset();
    rst_i = 1'b0; flush_i = 1'b0; req_valid_i = 1'b0; opcode_accept_i = 1'b0;
    tick();
    rst_i = 1'b1;
    exp_enc = '0; exp_errc = '0; sb.delete();
  endtask

  task automatic test_reset();
    rst_i = 1'b0; flush_i = 1'b0; req_valid_i = 1'b1; opcode_accept_i = 1'b0;
    req_op_i = OP_ADD; req_rd_i = 0; req_rs1_i = 0; req_rs2_i = 0; req_imm_i = 0;
    tick(); tick();
    checks++; if (opcode_valid_o !== 1'b0 || opcode_o !== 32'h0 || opcode_error_o !== 1'b0) begin
      fails++; $display("FAIL reset_outputs: got v=%b op=%h e=%b want 0/0/0", opcode_valid_o, opcode_o, opcode_error_o); end
    checks++; if (encoded_count_o !== 16'd0 || error_count_o !== 8'd0) begin
      fails++; $display("FAIL reset_counters: got %0d/%0d want 0/0", encoded_count_o, error_count_o); end
    checks++; if (req_accept_o !== 1'b0) begin
      fails++; $display("FAIL reset_accept: got %b want 0", req_accept_o); end
    req_valid_i = 1'b0; rst_i = 1'b1;
    #1;
    checks++; if (req_accept_o !== 1'b1) begin
      fails++; $display("FAIL reset_release_accept: got %b want 1", req_accept_o); end
    tick();
  endtask

  task automatic test_addi();
    do_reset();
    drive_req(OP_ADDI, 5'd1, 5'd0, 5'd0, 32'd5);
    #1;
    checks++; if (req_accept_o !== 1'b1) begin
      fails++; $display("FAIL addi_accept: got %b want 1", req_accept_o); end
    tick(); req_valid_i = 1'b0;
    checks++; if (opcode_valid_o !== 1'b1 || opcode_o !== 32'h00500093 || opcode_error_o !== 1'b0) begin
      fails++; $display("FAIL addi_word: got v=%b %h e=%b want 1 00500093 0", opcode_valid_o, opcode_o, opcode_error_o); end
    opcode_accept_i = 1'b1; tick(); opcode_accept_i = 1'b0;
    checks++; if (opcode_valid_o !== 1'b0 || opcode_o !== 32'h0 || encoded_count_o !== 16'd1) begin
      fails++; $display("FAIL addi_pop: got v=%b %h cnt=%0d want 0 0 1", opcode_valid_o, opcode_o, encoded_count_o); end
  endtask

  task automatic test_hold_order();
    do_reset();
    drive_req(OP_MUL, 5'd10, 5'd11, 5'd12, 32'd0); tick();
    drive_req(OP_BEQ, 5'd0, 5'd1, 5'd2, 32'd8); tick();
    req_valid_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++; if (opcode_valid_o !== 1'b1 || opcode_o !== 32'h02C58533) begin
        fails++; $display("FAIL hold_head[%0d]: got v=%b %h want 1 02C58533", i, opcode_valid_o, opcode_o); end
      tick();
    end
    opcode_accept_i = 1'b1; tick();
    checks++; if (opcode_valid_o !== 1'b1 || opcode_o !== 32'h00208463) begin
      fails++; $display("FAIL order_second: got v=%b %h want 1 00208463", opcode_valid_o, opcode_o); end
    tick(); opcode_accept_i = 1'b0;
    checks++; if (opcode_valid_o !== 1'b0 || encoded_count_o !== 16'd2) begin
      fails++; $display("FAIL order_drain: got v=%b cnt=%0d want 0 2", opcode_valid_o, encoded_count_o); end
  endtask

  task automatic test_lui_jal();
    do_reset();
    drive_req(OP_LUI, 5'd5, 5'd0, 5'd0, 32'h12345000); tick();
    drive_req(OP_JAL, 5'd1, 5'd0, 5'd0, 32'd2048); tick();
    req_valid_i = 1'b0; opcode_accept_i = 1'b1;
    checks++; if (opcode_o !== 32'h123452B7 || opcode_error_o !== 1'b0) begin
      fails++; $display("FAIL lui_word: got %h e=%b want 123452B7 0", opcode_o, opcode_error_o); end
    tick();
    checks++; if (opcode_o !== 32'h001000EF || opcode_error_o !== 1'b0) begin
      fails++; $display("FAIL jal_word: got %h e=%b want 001000EF 0", opcode_o, opcode_error_o); end
    tick(); opcode_accept_i = 1'b0;
  endtask

  task automatic test_error();
    do_reset();
    drive_req(OP_ADDI, 5'd1, 5'd2, 5'd0, 32'd2048); tick(); req_valid_i = 1'b0;
    checks++; if (opcode_valid_o !== 1'b1 || opcode_o !== 32'h0 || opcode_error_o !== 1'b1 || error_count_o !== 8'd1) begin
      fails++; $display("FAIL addi_err: got v=%b %h e=%b ec=%0d want 1 0 1 1", opcode_valid_o, opcode_o, opcode_error_o, error_count_o); end
    opcode_accept_i = 1'b1; tick(); opcode_accept_i = 1'b0;
  endtask

  task automatic test_boundaries();
    logic [5:0] ops [0:15] = '{OP_ADDI, OP_ADDI, OP_ADDI, OP_BEQ, OP_BEQ, OP_BEQ, OP_BNE, OP_JAL,
                               OP_JAL, OP_LUI, OP_LUI, OP_SLLI, OP_SLLI, OP_CSRRW, OP_CSRRW, 6'd63};
    logic [31:0] imms [0:15] = '{32'd2047, -32'sd2048, -32'sd2049, 32'd4094, 32'd4096, -32'sd4096,
                                 32'd3, 32'd1048574, 32'd1048576, 32'h00001000, 32'h00001001,
                                 32'd31, 32'd32, 32'h00000FFF, 32'h00001000, 32'd0};
    logic        errs [0:15] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1,
                                 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [32:0] want;
    do_reset();
    for (int i = 0; i < 16; i++) begin
      drive_req(ops[i], 5'd3, 5'd4, 5'd5, imms[i]); tick(); req_valid_i = 1'b0;
      want = ref_encode(ops[i], 5'd3, 5'd4, 5'd5, imms[i]);
      checks++; if (opcode_error_o !== errs[i] || opcode_o !== want[31:0]) begin
        fails++; $display("FAIL boundary[%0d]: got %h e=%b want %h e=%b", i, opcode_o, opcode_error_o, want[31:0], errs[i]); end
      opcode_accept_i = 1'b1; tick(); opcode_accept_i = 1'b0;
    end
    checks++; if (error_count_o !== 8'd8 || encoded_count_o !== 16'd16) begin
      fails++; $display("FAIL boundary_counts: got ec=%0d enc=%0d want 8 16", error_count_o, encoded_count_o); end
  endtask

  task automatic test_full_flush();
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      drive_req(OP_ADDI, 5'(i), 5'd0, 5'd0, 32'(i));
      #1;
      checks++; if (req_accept_o !== 1'b1) begin
        fails++; $display("FAIL fill_accept[%0d]: got %b want 1", i, req_accept_o); end
      tick();
    end
    drive_req(OP_ADDI, 5'd9, 5'd0, 5'd0, 32'd9); opcode_accept_i = 1'b1;
    #1;
    checks++; if (req_accept_o !== 1'b0) begin
      fails++; $display("FAIL full_no_bypass: got %b want 0", req_accept_o); end
    tick();
    req_valid_i = 1'b0; flush_i = 1'b1;
    #1;
    checks++; if (req_accept_o !== 1'b0) begin
      fails++; $display("FAIL flush_accept: got %b want 0", req_accept_o); end
    tick(); flush_i = 1'b0; opcode_accept_i = 1'b0;
    checks++; if (opcode_valid_o !== 1'b0 || opcode_o !== 32'h0 || encoded_count_o !== 16'd1) begin
      fails++; $display("FAIL flush_empty: got v=%b %h enc=%0d want 0 0 1", opcode_valid_o, opcode_o, encoded_count_o); end
  endtask

  task automatic test_saturation();
    do_reset();
    opcode_accept_i = 1'b1;
    drive_req(OP_ADDI, 5'd1, 5'd1, 5'd0, 32'd4096);
    repeat (270) tick();
    req_valid_i = 1'b0;
    checks++; if (error_count_o !== 8'd255 || encoded_count_o !== 16'd269) begin
      fails++; $display("FAIL err_saturate: got ec=%0d enc=%0d want 255 269", error_count_o, encoded_count_o); end
    tick(); opcode_accept_i = 1'b0;
  endtask

  task automatic test_reset_midstream();
    do_reset();
    drive_req(OP_ADDI, 5'd1, 5'd0, 5'd0, 32'd2048); tick();
    drive_req(OP_ADDI, 5'd1, 5'd0, 5'd0, 32'd1); tick();
    drive_req(OP_ADDI, 5'd1, 5'd0, 5'd0, 32'd2); tick();
    req_valid_i = 1'b0; opcode_accept_i = 1'b1; tick(); opcode_accept_i = 1'b0;
    checks++; if (opcode_valid_o !== 1'b1 || encoded_count_o !== 16'd1 || error_count_o !== 8'd1) begin
      fails++; $display("FAIL midstream_pre: got v=%b enc=%0d ec=%0d want 1 1 1", opcode_valid_o, encoded_count_o, error_count_o); end
    rst_i = 1'b0; drive_req(OP_ADDI, 5'd2, 5'd0, 5'd0, 32'd3);
    #1;
    checks++; if (req_accept_o !== 1'b0) begin
      fails++; $display("FAIL midstream_accept: got %b want 0", req_accept_o); end
    tick();
    checks++; if (opcode_valid_o !== 1'b0 || opcode_o !== 32'h0 || encoded_count_o !== 16'd0 ||
                  error_count_o !== 8'd0 || req_accept_o !== 1'b0) begin
      fails++; $display("FAIL midstream_reset: got v=%b %h enc=%0d ec=%0d acc=%b want all 0",
                        opcode_valid_o, opcode_o, encoded_count_o, error_count_o, req_accept_o); end
    rst_i = 1'b1; req_valid_i = 1'b0; tick();
    checks++; if (opcode_valid_o !== 1'b0) begin
      fails++; $display("FAIL midstream_after: got v=%b want 0", opcode_valid_o); end
  endtask

  task automatic test_random();
    logic [32:0] ent, head;
    bit do_push, do_pop;
    do_reset();
    for (int cyc = 0; cyc < 600; cyc++) begin
      head = (sb.size() != 0) ? sb[0] : 33'h0;
      checks++; if (opcode_valid_o !== (sb.size() != 0) || opcode_o !== head[31:0] || opcode_error_o !== head[32]) begin
        fails++; $display("FAIL rand_head c%0d: got v=%b %h e=%b want v=%b %h e=%b", cyc,
                          opcode_valid_o, opcode_o, opcode_error_o, sb.size() != 0, head[31:0], head[32]); end
      checks++; if (encoded_count_o !== exp_enc || error_count_o !== exp_errc) begin
        fails++; $display("FAIL rand_counts c%0d: got %0d/%0d want %0d/%0d", cyc,
                          encoded_count_o, error_count_o, exp_enc, exp_errc); end
      req_valid_i = ($urandom_range(0, 3) != 0);
      req_op_i = 6'($urandom_range(0, 63));
      req_rd_i = 5'($urandom); req_rs1_i = 5'($urandom); req_rs2_i = 5'($urandom);
      case ($urandom_range(0, 4))
        0: req_imm_i = 32'(int'($urandom_range(0, 8200)) - 4100);
        1: req_imm_i = $urandom();
        2: req_imm_i = $urandom() & 32'hFFFFF000;
        3: req_imm_i = 32'($urandom_range(0, 40));
        default: req_imm_i = 32'(bnd[$urandom_range(0, 12)]);
      endcase
      flush_i = ($urandom_range(0, 31) == 0);
      opcode_accept_i = ($urandom_range(0, 2) != 0);
      #1;
      checks++; if (req_accept_o !== (!flush_i && sb.size() < DEPTH)) begin
        fails++; $display("FAIL rand_accept c%0d: got %b want %b", cyc, req_accept_o, !flush_i && sb.size() < DEPTH); end
      if (flush_i) sb.delete();
      else begin
        do_push = req_valid_i && sb.size() < DEPTH;
        do_pop  = opcode_accept_i && sb.size() != 0;
        if (do_pop) begin void'(sb.pop_front()); exp_enc = exp_enc + 16'd1; end
        if (do_push) begin
          ent = ref_encode(req_op_i, req_rd_i, req_rs1_i, req_rs2_i, req_imm_i);
          sb.push_back(ent);
          if (ent[32] && exp_errc != 8'hFF) exp_errc = exp_errc + 8'd1;
        end
      end
      tick();
    end
    req_valid_i = 1'b0; flush_i = 1'b0; opcode_accept_i = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    rst_i = 1'b0; flush_i = 1'b0; req_valid_i = 1'b0; opcode_accept_i = 1'b0;
    req_op_i = '0; req_rd_i = '0; req_rs1_i = '0; req_rs2_i = '0; req_imm_i = '0;
    exp_enc = '0; exp_errc = '0;
    tick();
    test_reset();
    test_addi();
    test_hold_order();
    test_lui_jal();
    test_error();
    test_boundaries();
    test_full_flush();
    test_saturation();
    test_reset_midstream();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/biriscv_inst_encoder.md
Name: biriscv_inst_encoder

Overview:
- Converts field-level instruction requests (operation, rd, rs1, rs2, immediate) into 32-bit RV32IM opcode words.
- Queues the encoded words in a small FIFO and presents them on a valid/accept interface to an instruction-injection point: debug program buffer, self-test sequencer or fetch stub.
- It is the encoder counterpart of the core instruction decoder. Requests whose fields cannot be encoded are emitted as 32'h00000000 with an error flag, so the decoder flags them invalid.

Parameters:
- DEPTH, 4: FIFO entries; power of two, 2..16.
- ENABLE_MULDIV, 1: when 0, MUL/DIV/REM ops are treated as unencodable.

Ports:
- clk_i  in  1  core clock.
- rst_i  in  1  synchronous, active-low reset.
- flush_i  in  1  discards all queued words.
- req_valid_i  in  1  request present.
- req_accept_o  out  1  request taken this cycle.
- req_op_i  in  6  operation select (package enum).
- req_rd_i  in  5  destination register.
- req_rs1_i  in  5  source 1; holds zimm for CSR*I ops.
- req_rs2_i  in  5  source 2.
- req_imm_i  in  32  immediate: byte offset, full U value, shamt, or CSR address.
- opcode_valid_o  out  1  head word valid.
- opcode_o  out  32  encoded instruction.
- opcode_error_o  out  1  head word came from an unencodable request.
- opcode_accept_i  in  1  consumer takes the head word.
- encoded_count_o  out  16  words popped; wraps.
- error_count_o  out  8  error words pushed; saturates at 255.

Behaviour:
Reset (rst_i=0 at a clock edge):
- FIFO emptied.
- opcode_valid_o=0, opcode_o=0, opcode_error_o=0.
- Both counters 0.
- req_accept_o=0 during reset.

Push:
- req_accept_o = rst_i & ~flush_i & (count < DEPTH).
- A push occurs when req_valid_i & req_accept_o.
- Encoding is combinational into the FIFO write, so the word is visible on opcode_o the cycle after acceptance when the FIFO was empty. Latency is 1 cycle.
- There is no full-FIFO bypass. When the FIFO is full, accept stays 0 even if a pop happens in the same cycle.

Pop:
- A pop occurs when opcode_valid_o & opcode_accept_i.
- opcode_o and opcode_error_o hold stable while valid and not accepted.
- When the FIFO is empty, opcode_o and opcode_error_o read 0.

Simultaneous push and pop (FIFO not full): count is unchanged and pointers wrap modulo DEPTH.

Flush:
- Takes priority over push and pop in the same cycle: count, pointers and valid are cleared next cycle.
- encoded_count_o does not increment in the flush cycle.

Encoding formats:
- R-type: ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
- I-type: ADDI, SLTI, SLTIU, XORI, ORI, ANDI, JALR, LB, LH, LW, LBU, LHU.
- Shift-immediate: SLLI, SRLI, SRAI (funct7 0x00 or 0x20).
- S-type: SB, SH, SW.
- B-type: BEQ, BNE, BLT, BGE, BLTU, BGEU.
- U-type: LUI, AUIPC; opcode_o[31:12] = imm[31:12].
- J-type: JAL.
- CSR: CSRRW, CSRRS, CSRRC, CSRRWI, CSRRSI, CSRRCI; imm[11:0] is the CSR address.
- System: ECALL=0x00000073, EBREAK=0x00100073, WFI=0x10500073, FENCE=0x0000000F; these ignore all fields.

Error conditions (push 32'h00000000 with error=1; error_count_o increments):
- I/S immediate outside [-2048, 2047].
- B immediate outside [-4096, 4094] or odd.
- J immediate outside [-2^20, 2^20-2] or odd.
- U immediate with imm[11:0] != 0.
- Shamt > 31.
- CSR address > 0xFFF.
- Undefined op code.
- Muldiv op with ENABLE_MULDIV=0.

Decomposition:
- Package biriscv_enc_pkg: the op enum (6-bit), major opcode constants (0x13, 0x33, 0x03, 0x23, 0x63, 0x37, 0x17, 0x6F, 0x67, 0x73, 0x0F), funct3/funct7 constants, and the system-instruction constants.
- Sub-module biriscv_enc_fifo: a generic DEPTH x 33 synchronous FIFO with count, flush and synchronous active-low reset.
- The encoder itself is combinational logic plus the counters.

Test Plan:
- ADDI rd=1 rs1=0 imm=5 pushed into an empty FIFO -> next cycle opcode_valid_o=1, opcode_o=0x00500093, error=0.
- MUL rd=10 rs1=11 rs2=12, then BEQ rs1=1 rs2=2 imm=8, with opcode_accept_i=0 -> words held in order. Accepting gives 0x02C58533, then 0x00208463; encoded_count_o=2.
- LUI rd=5 imm=0x12345000 -> 0x123452B7. JAL rd=1 imm=2048 -> 0x001000EF.
- ADDI imm=2048 -> opcode_o=0x00000000, error=1, error_count_o=1.
- Five pushes with DEPTH=4 and the consumer stalled -> req_accept_o=0 on the 5th even with a concurrent pop. flush_i next cycle -> opcode_valid_o=0, FIFO empty.
- Reset asserted mid-stream with two queued words -> after one edge valid=0, both counters 0, req_accept_o=0 while rst_i=0.
